// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch redirect, and
// instruction/data memory wait handling with a deferred-redirect latch.
module hazard_ctrl #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs1_ID,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs2_ID,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd_EX,
    input  logic                      i_memread_EX,
    input  logic                      i_pcsrc_EX,
    input  logic [DATA_WIDTH-1:0]     i_pctarget_EX,
    input  logic                      i_imem_ready,
    input  logic                      i_dmem_req_MEM,
    input  logic                      i_dmem_ready,
    output logic                      o_stall_IF,
    output logic                      o_stall_ID,
    output logic                      o_stall_EX,
    output logic                      o_stall_MEM,
    output logic                      o_flush_ID,
    output logic                      o_flush_EX,
    output logic                      o_pcsrc_IF,
    output logic [DATA_WIDTH-1:0]     o_pctarget_IF,
    output logic [1:0]                o_state,
    output logic                      o_redir_pending,
    output logic [15:0]               o_stall_cnt
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IWAIT = 2'd1,
        DWAIT = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   pending_q, pending_d;
    logic [DATA_WIDTH-1:0]  target_q, target_d;
    logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;

    logic dstall, istall, lu;

    assign dstall = i_dmem_req_MEM & ~i_dmem_ready;
    assign istall = ~i_imem_ready;
    assign lu     = i_memread_EX & (i_rd_EX != '0)
                  & ((i_rd_EX == i_rs1_ID) | (i_rd_EX == i_rs2_ID));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pending_q   <= 1'b0;
            target_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            target_q    <= target_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Priority-ordered hazard resolution and next-state logic
    always_comb begin
        state_d       = RUN;
        pending_d     = pending_q;
        target_d      = target_q;
        o_stall_IF    = 1'b0;
        o_stall_ID    = 1'b0;
        o_stall_EX    = 1'b0;
        o_stall_MEM   = 1'b0;
        o_flush_ID    = 1'b0;
        o_flush_EX    = 1'b0;
        o_pcsrc_IF    = 1'b0;
        o_pctarget_IF = target_q;

        if (dstall) begin
            state_d = DWAIT;
        end else if (istall) begin
            state_d = IWAIT;
        end

        if (dstall) begin
            o_stall_IF  = 1'b1;
            o_stall_ID  = 1'b1;
            o_stall_EX  = 1'b1;
            o_stall_MEM = 1'b1;
        end else if (i_pcsrc_EX && !istall) begin
            // A fresh redirect supersedes any older deferred one
            o_flush_ID    = 1'b1;
            o_flush_EX    = 1'b1;
            o_pcsrc_IF    = 1'b1;
            o_pctarget_IF = i_pctarget_EX;
            pending_d     = 1'b0;
        end else if (i_pcsrc_EX) begin
            o_flush_ID = 1'b1;
            o_flush_EX = 1'b1;
            o_stall_IF = 1'b1;
            pending_d  = 1'b1;
            target_d   = i_pctarget_EX;
        end else if (istall) begin
            o_stall_IF = 1'b1;
            o_stall_ID = 1'b1;
            o_flush_EX = 1'b1;
        end else if (pending_q) begin
            // Fetch finished on the wrong path: drop it and redirect now
            o_pcsrc_IF    = 1'b1;
            o_pctarget_IF = target_q;
            o_flush_ID    = 1'b1;
            pending_d     = 1'b0;
        end else if (lu) begin
            o_stall_IF = 1'b1;
            o_stall_ID = 1'b1;
            o_flush_EX = 1'b1;
        end

        stall_cnt_d = stall_cnt_q;
        if (o_stall_IF && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    assign o_state         = state_q;
    assign o_redir_pending = pending_q;
    assign o_stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hand-computed expectations per scenario.
module tb_hazard_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rs1, rs2, rd;
    logic          memread, pcsrc, imem_ready, dmem_req, dmem_ready;
    logic [DW-1:0] pctarget;
    logic          s_if, s_id, s_ex, s_mem, f_id, f_ex, pcsrc_if;
    logic [DW-1:0] pctarget_if;
    logic [1:0]    state;
    logic          pending;
    logic [15:0]   cnt;

    int n_vec = 0;
    int n_err = 0;

    // {stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX, pcsrc_IF}
    logic [6:0] ctl;
    assign ctl = {s_if, s_id, s_ex, s_mem, f_id, f_ex, pcsrc_if};

    always #5 clk = ~clk;

    hazard_ctrl #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_rs1_ID(rs1), .i_rs2_ID(rs2), .i_rd_EX(rd), .i_memread_EX(memread),
        .i_pcsrc_EX(pcsrc), .i_pctarget_EX(pctarget),
        .i_imem_ready(imem_ready), .i_dmem_req_MEM(dmem_req), .i_dmem_ready(dmem_ready),
        .o_stall_IF(s_if), .o_stall_ID(s_id), .o_stall_EX(s_ex), .o_stall_MEM(s_mem),
        .o_flush_ID(f_id), .o_flush_EX(f_ex),
        .o_pcsrc_IF(pcsrc_if), .o_pctarget_IF(pctarget_if),
        .o_state(state), .o_redir_pending(pending), .o_stall_cnt(cnt)
    );

    task automatic idle();
        rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3; memread = 1'b0;
        pcsrc = 1'b0; pctarget = '0;
        imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #3;
        n_vec++;
        if ({ctl, state, pending, cnt, pctarget_if} !== {7'b0, 2'd0, 1'b0, 16'd0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_state: ctl=%b st=%0d pend=%0b cnt=%0d tgt=%h want all zero",
                     ctl, state, pending, cnt, pctarget_if);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        n_vec++;
        if ({ctl, state} !== {7'b0, 2'd0}) begin
            n_err++;
            $display("FAIL idle_run: ctl=%b st=%0d want ctl=0 st=0", ctl, state);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk); idle(); memread = 1'b1; rd = 5'd5; rs2 = 5'd5; #1;
        n_vec++;
        if (ctl !== 7'b1100010) begin
            n_err++; $display("FAIL lu_rs2: ctl=%b want 1100010", ctl);
        end
        // Next cycle EX holds the bubble
        @(negedge clk); idle(); rs2 = 5'd5; #1;
        n_vec++;
        if (ctl !== 7'b0) begin
            n_err++; $display("FAIL lu_one_bubble: ctl=%b want 0000000", ctl);
        end
        @(negedge clk); idle(); memread = 1'b1; rd = 5'd7; rs1 = 5'd7; #1;
        n_vec++;
        if (ctl !== 7'b1100010) begin
            n_err++; $display("FAIL lu_rs1: ctl=%b want 1100010", ctl);
        end
        @(negedge clk); idle(); memread = 1'b1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; #1;
        n_vec++;
        if (ctl !== 7'b0) begin
            n_err++; $display("FAIL lu_x0: ctl=%b want 0000000", ctl);
        end
        @(negedge clk); idle(); memread = 1'b1; rd = 5'd9; #1;
        n_vec++;
        if (ctl !== 7'b0) begin
            n_err++; $display("FAIL lu_nomatch: ctl=%b want 0000000", ctl);
        end
    endtask

    task automatic test_branch();
        @(negedge clk); idle(); pcsrc = 1'b1; pctarget = 32'h100; #1;
        n_vec++;
        if ({ctl, pctarget_if} !== {7'b0000111, 32'h100}) begin
            n_err++; $display("FAIL branch_taken: ctl=%b tgt=%h want 0000111 00000100", ctl, pctarget_if);
        end
    endtask

    task automatic test_branch_fetch_wait();
        @(negedge clk); idle(); imem_ready = 1'b0; pcsrc = 1'b1; pctarget = 32'h200; #1;
        n_vec++;
        if ({ctl, pending} !== {7'b1000110, 1'b0}) begin
            n_err++; $display("FAIL bw_first: ctl=%b pend=%0b want 1000110 0", ctl, pending);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); idle(); imem_ready = 1'b0; #1;
            n_vec++;
            if ({ctl, pending, state, pctarget_if} !== {7'b1100010, 1'b1, 2'd1, 32'h200}) begin
                n_err++;
                $display("FAIL bw_wait%0d: ctl=%b pend=%0b st=%0d tgt=%h want 1100010 1 1 00000200",
                         i, ctl, pending, state, pctarget_if);
            end
        end
        @(negedge clk); idle(); #1;
        n_vec++;
        if ({ctl, pctarget_if} !== {7'b0000101, 32'h200}) begin
            n_err++; $display("FAIL bw_redirect: ctl=%b tgt=%h want 0000101 00000200", ctl, pctarget_if);
        end
        @(negedge clk); idle(); #1;
        n_vec++;
        if ({ctl, pending, state} !== {7'b0, 1'b0, 2'd0}) begin
            n_err++; $display("FAIL bw_cleared: ctl=%b pend=%0b st=%0d want 0 0 0", ctl, pending, state);
        end
    endtask

    task automatic test_newest_target();
        @(negedge clk); idle(); imem_ready = 1'b0; pcsrc = 1'b1; pctarget = 32'h400;
        @(negedge clk); idle(); imem_ready = 1'b0; pcsrc = 1'b1; pctarget = 32'h500;
        @(negedge clk); idle(); #1;
        n_vec++;
        if ({ctl, pctarget_if} !== {7'b0000101, 32'h500}) begin
            n_err++; $display("FAIL newest_target: ctl=%b tgt=%h want 0000101 00000500", ctl, pctarget_if);
        end
    endtask

    task automatic test_dwait_branch();
        @(negedge clk); idle(); dmem_req = 1'b1; dmem_ready = 1'b0; pcsrc = 1'b1; pctarget = 32'h300; #1;
        n_vec++;
        if (ctl !== 7'b1111000) begin
            n_err++; $display("FAIL dw_first: ctl=%b want 1111000", ctl);
        end
        @(negedge clk); #1;
        n_vec++;
        if ({ctl, state, pending} !== {7'b1111000, 2'd2, 1'b0}) begin
            n_err++; $display("FAIL dw_second: ctl=%b st=%0d pend=%0b want 1111000 2 0", ctl, state, pending);
        end
        @(negedge clk); dmem_ready = 1'b1; #1;
        n_vec++;
        if ({ctl, pctarget_if, state} !== {7'b0000111, 32'h300, 2'd2}) begin
            n_err++; $display("FAIL dw_release: ctl=%b tgt=%h st=%0d want 0000111 00000300 2",
                              ctl, pctarget_if, state);
        end
        @(negedge clk); idle(); #1;
        n_vec++;
        if (state !== 2'd0) begin
            n_err++; $display("FAIL dw_back_run: st=%0d want 0", state);
        end
    endtask

    task automatic test_counter();
        @(negedge clk); rst_n = 1'b0; idle(); #1;
        n_vec++;
        if (cnt !== 16'd0) begin
            n_err++; $display("FAIL cnt_reset: cnt=%0d want 0", cnt);
        end
        @(negedge clk); rst_n = 1'b1; imem_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_vec++;
        if (cnt !== 16'd3) begin
            n_err++; $display("FAIL cnt_three: cnt=%0d want 3", cnt);
        end
        repeat (70000) @(posedge clk);
        @(negedge clk); #1;
        n_vec++;
        if (cnt !== 16'hFFFF) begin
            n_err++; $display("FAIL cnt_saturate: cnt=%h want ffff", cnt);
        end
        // Leave a deferred redirect in flight, then reset asynchronously
        @(negedge clk); pcsrc = 1'b1; pctarget = 32'h600;
        @(negedge clk); pcsrc = 1'b0; #1;
        n_vec++;
        if ({cnt, pending, state} !== {16'hFFFF, 1'b1, 2'd1}) begin
            n_err++; $display("FAIL cnt_hold: cnt=%h pend=%0b st=%0d want ffff 1 1", cnt, pending, state);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({cnt, pending, state, pctarget_if} !== {16'd0, 1'b0, 2'd0, 32'd0}) begin
            n_err++; $display("FAIL async_reset: cnt=%h pend=%0b st=%0d tgt=%h want 0 0 0 0",
                              cnt, pending, state, pctarget_if);
        end
        @(negedge clk); idle(); rst_n = 1'b1;
        @(negedge clk); #1;
        n_vec++;
        if ({ctl, pending, state} !== {7'b0, 1'b0, 2'd0}) begin
            n_err++; $display("FAIL post_reset: ctl=%b pend=%0b st=%0d want 0 0 0", ctl, pending, state);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_branch_fetch_wait();
        test_newest_target();
        test_dwait_branch();
        test_counter();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
